// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST frame sequencer.
// Defaults target a 50 MHz system clock and a 28x28 image with 10 classes.
package mnist_pkg;

  localparam int          N_PIXELS       = 784;
  localparam int          N_CLASSES      = 10;
  localparam logic [7:0]  SYNC0          = 8'hAA;
  localparam logic [7:0]  SYNC1          = 8'h55;
  localparam int          TIMEOUT_CYCLES = 5_000_000;
  localparam int          PAD_GAP        = 16;
  localparam int          PIX_CNT_W      = $clog2(N_PIXELS + 1);
  localparam int          CLS_W          = 4;
  localparam int          SCORE_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LOAD = 3'd2,
    ST_PAD  = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } frame_state_e;

endpackage

// File: rtl/mnist_argmax_acc.sv
// Running signed argmax over a stream of scores; i_first restarts the search.
// Outputs already include the sample presented this cycle, so a caller can latch the final winner on the last strobe.
module mnist_argmax_acc
  import mnist_pkg::*;
#(
  parameter int W     = SCORE_W,
  parameter int IDX_W = CLS_W
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic signed [W-1:0]  i_data,
  output logic signed [W-1:0]  o_max,
  output logic [IDX_W-1:0]     o_idx
);

  logic signed [W-1:0] r_max;
  logic [IDX_W-1:0]    r_idx;
  logic                w_take;

  // Strict compare: an equal later score never displaces the lower index.
  assign w_take = i_valid && (i_first || (i_data > r_max));
  assign o_max  = w_take ? i_data : r_max;
  assign o_idx  = w_take ? i_idx  : r_idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_max <= '0;
      r_idx <= '0;
    end else if (w_take) begin
      r_max <= i_data;
      r_idx <= i_idx;
    end
  end

endmodule

// File: rtl/mnist_frame_ctrl.sv
// Frame sequencer: finds the AA 55 header, forwards one frame of pixels to the core,
// zero-pads frames that stall, and reports the argmax of the core's class scores.
module mnist_frame_ctrl
  import mnist_pkg::*;
#(
  parameter int         N_PIXELS       = mnist_pkg::N_PIXELS,
  parameter int         N_CLASSES      = mnist_pkg::N_CLASSES,
  parameter logic [7:0] SYNC0          = mnist_pkg::SYNC0,
  parameter logic [7:0] SYNC1          = mnist_pkg::SYNC1,
  parameter int         TIMEOUT_CYCLES = mnist_pkg::TIMEOUT_CYCLES,
  parameter int         PAD_GAP        = mnist_pkg::PAD_GAP
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  output logic                       core_valid_in,
  output logic [7:0]                 core_pixel,
  input  logic signed [SCORE_W-1:0]  core_result,
  input  logic                       core_result_valid,
  output logic                       done,
  output logic [CLS_W-1:0]           class_idx,
  output logic signed [SCORE_W-1:0]  max_score,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       rx_drop,
  output logic [15:0]                frame_cnt,
  output frame_state_e               o_dbg_state
);

  localparam int PIX_W = $clog2(N_PIXELS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(PAD_GAP + 1);
  localparam int OUT_W = CLS_W + 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIXELS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(PAD_GAP - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(N_CLASSES - 1);

  frame_state_e                r_state;
  logic [PIX_W-1:0]            r_pix_cnt;
  logic [TMR_W-1:0]            r_timer;
  logic [GAP_W-1:0]            r_gap_cnt;
  logic [OUT_W-1:0]            r_out_cnt;
  logic                        r_frame_bad;
  logic                        r_core_valid;
  logic [7:0]                  r_core_pixel;
  logic                        r_done;
  logic [CLS_W-1:0]            r_class_idx;
  logic signed [SCORE_W-1:0]   r_max_score;
  logic                        r_err_timeout;
  logic                        r_rx_drop;
  logic [15:0]                 r_frame_cnt;

  logic                        w_acc_valid;
  logic                        w_acc_first;
  logic signed [SCORE_W-1:0]   w_acc_max;
  logic [CLS_W-1:0]            w_acc_idx;

  assign w_acc_valid = (r_state == ST_WAIT) && core_result_valid;
  assign w_acc_first = (r_out_cnt == '0);

  mnist_argmax_acc #(
    .W     (SCORE_W),
    .IDX_W (CLS_W)
  ) u_argmax (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_valid   (w_acc_valid),
    .i_first   (w_acc_first),
    .i_idx     (r_out_cnt[CLS_W-1:0]),
    .i_data    (core_result),
    .o_max     (w_acc_max),
    .o_idx     (w_acc_idx)
  );

  // A byte arriving on the expiry cycle always wins over the timeout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_pix_cnt     <= '0;
      r_timer       <= '0;
      r_gap_cnt     <= '0;
      r_out_cnt     <= '0;
      r_frame_bad   <= 1'b0;
      r_core_valid  <= 1'b0;
      r_core_pixel  <= '0;
      r_done        <= 1'b0;
      r_class_idx   <= '0;
      r_max_score   <= '0;
      r_err_timeout <= 1'b0;
      r_rx_drop     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_core_valid  <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_rx_drop     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (rx_valid && (rx_byte == SYNC0)) r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (rx_valid) begin
            r_timer <= '0;
            if (rx_byte == SYNC1) begin
              r_state     <= ST_LOAD;
              r_pix_cnt   <= '0;
              r_frame_bad <= 1'b0;
            end else if (rx_byte != SYNC0) begin
              r_state <= ST_IDLE;
            end
          end else if (r_timer == TMR_LAST) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            r_timer      <= '0;
            r_core_valid <= 1'b1;
            r_core_pixel <= rx_byte;
            r_pix_cnt    <= r_pix_cnt + 1'b1;
            if (r_pix_cnt == PIX_LAST) begin
              r_state   <= ST_WAIT;
              r_out_cnt <= '0;
            end
          end else if (r_timer == TMR_LAST) begin
            r_state       <= ST_PAD;
            r_timer       <= '0;
            r_gap_cnt     <= '0;
            r_err_timeout <= 1'b1;
            r_frame_bad   <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_PAD: begin
          r_rx_drop <= rx_valid;
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt    <= '0;
            r_core_valid <= 1'b1;
            r_core_pixel <= '0;
            r_pix_cnt    <= r_pix_cnt + 1'b1;
            if (r_pix_cnt == PIX_LAST) begin
              r_state   <= ST_WAIT;
              r_out_cnt <= '0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          r_rx_drop <= rx_valid;
          if (core_result_valid) begin
            r_out_cnt <= r_out_cnt + 1'b1;
            // Results are published on entry to DONE so done lands one cycle after the last score.
            if (r_out_cnt == OUT_LAST) begin
              r_state <= ST_DONE;
              if (!r_frame_bad) begin
                r_done      <= 1'b1;
                r_class_idx <= w_acc_idx;
                r_max_score <= w_acc_max;
                r_frame_cnt <= r_frame_cnt + 16'd1;
              end
            end
          end
        end
        ST_DONE: begin
          r_rx_drop <= rx_valid;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_valid_in = r_core_valid;
  assign core_pixel    = r_core_pixel;
  assign done          = r_done;
  assign class_idx     = r_class_idx;
  assign max_score     = r_max_score;
  assign busy          = (r_state != ST_IDLE);
  assign err_timeout   = r_err_timeout;
  assign rx_drop       = r_rx_drop;
  assign frame_cnt     = r_frame_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mnist_frame_ctrl.sv
// Directed-plus-random bench for mnist_frame_ctrl with a scoreboard of forwarded pixels
// and a reference argmax computed straight from the class scores.
module tb_mnist_frame_ctrl;
  import mnist_pkg::*;

  localparam int NPIX  = 784;
  localparam int NCLS  = 10;
  localparam int T_TMO = 40;
  localparam int GAP   = 16;

  typedef logic signed [31:0] score_arr_t [NCLS];

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [7:0]         rx_byte = '0;
  logic               rx_valid = 1'b0;
  logic signed [31:0] core_result = '0;
  logic               core_result_valid = 1'b0;
  logic               core_valid_in;
  logic [7:0]         core_pixel;
  logic               done;
  logic [3:0]         class_idx;
  logic signed [31:0] max_score;
  logic               busy;
  logic               err_timeout;
  logic               rx_drop;
  logic [15:0]        frame_cnt;
  frame_state_e       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_drop = 0;
  int n_tmo = 0;
  int n_done = 0;
  int tmo_cyc = 0;
  int rd = 0;
  int last_byte_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];

  int          m_frame_cnt = 0;
  logic [3:0]  m_class = '0;
  logic [31:0] m_score = '0;

  mnist_frame_ctrl #(
    .N_PIXELS       (NPIX),
    .N_CLASSES      (NCLS),
    .TIMEOUT_CYCLES (T_TMO),
    .PAD_GAP        (GAP)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .rx_byte           (rx_byte),
    .rx_valid          (rx_valid),
    .core_valid_in     (core_valid_in),
    .core_pixel        (core_pixel),
    .core_result       (core_result),
    .core_result_valid (core_result_valid),
    .done              (done),
    .class_idx         (class_idx),
    .max_score         (max_score),
    .busy              (busy),
    .err_timeout       (err_timeout),
    .rx_drop           (rx_drop),
    .frame_cnt         (frame_cnt),
    .o_dbg_state       (dbg_state)
  );

  // Clock, cycle counter and watchdog
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Monitor: records forwarded pixels and pulse events on the falling edge
  always @(negedge sys_clk) begin
    if (core_valid_in) begin
      got_q.push_back(core_pixel);
      got_t.push_back(cyc);
    end
    if (rx_drop)     n_drop <= n_drop + 1;
    if (err_timeout) begin
      n_tmo   <= n_tmo + 1;
      tmo_cyc <= cyc;
    end
    if (done)        n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap);
    last_byte_cyc = cyc;
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_header();
    send_byte(8'hAA, $urandom_range(0, 3));
    send_byte(8'h55, $urandom_range(0, 3));
  endtask

  // long_at: pixel index followed by T_TMO-1 idle cycles, so the next byte lands on the expiry cycle
  task automatic send_pixels(input int n, input int long_at);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, (i == long_at) ? T_TMO - 1 : int'($urandom_range(0, 3)));
    end
  endtask

  task automatic send_results(input score_arr_t s);
    for (int i = 0; i < NCLS; i++) begin
      core_result       = s[i];
      core_result_valid = 1'b1;
      tick();
      core_result_valid = 1'b0;
      if (i != NCLS - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic random_scores(output score_arr_t s);
    for (int i = 0; i < NCLS; i++) s[i] = 32'(int'($urandom_range(0, 20)) - 10);
  endtask

  // Reference: first index holding the largest signed score
  task automatic model_argmax(input score_arr_t s, output logic [3:0] idx, output logic [31:0] sc);
    int best;
    best = 0;
    for (int i = 1; i < NCLS; i++) if (s[i] > s[best]) best = i;
    idx = 4'(best);
    sc  = s[best];
  endtask

  task automatic finish_frame(input string tag, input score_arr_t s, input bit good);
    logic [3:0]  e_idx;
    logic [31:0] e_sc;
    int          done_snap;
    done_snap = n_done;
    send_results(s);
    if (good) begin
      model_argmax(s, e_idx, e_sc);
      m_class = e_idx;
      m_score = e_sc;
      m_frame_cnt++;
    end
    chk($sformatf("%s_done", tag), 32'(done), 32'(good));
    chk($sformatf("%s_class", tag), 32'(class_idx), 32'(m_class));
    chk($sformatf("%s_score", tag), max_score, m_score);
    chk($sformatf("%s_frame_cnt", tag), 32'(frame_cnt), 32'(m_frame_cnt[15:0]));
    tick();
    chk($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    tick();
    chk($sformatf("%s_done_count", tag), 32'(n_done - done_snap), 32'(good));
  endtask

  // Scoreboard: compare every pixel forwarded since the last call with the expected queue
  task automatic check_pixels(input string tag);
    int n;
    tick();
    tick();
    n = got_q.size() - rd;
    chk($sformatf("%s_pix_count", tag), 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (rd + i) < got_q.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), 32'(got_q[rd + i]), 32'(exp_q[i]));
    rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic wait_pixels(input int target, input int budget);
    int b;
    b = budget;
    while ((got_q.size() - rd) < target && b > 0) begin
      tick();
      b--;
    end
  endtask

  initial begin
    score_arr_t s;
    int snap;
    int snap_tmo;
    int base;
    int viol;
    int b;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(core_valid_in), 32'd0);
    chk("rst_pixel", 32'(core_pixel), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_class", 32'(class_idx), 32'd0);
    chk("rst_score", max_score, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(err_timeout), 32'd0);
    chk("rst_drop", 32'(rx_drop), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    sys_rst_n = 1'b1;
    tick();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Junk in IDLE is ignored silently; a stray score in IDLE changes nothing
    snap = n_drop;
    send_byte(8'h12, 0);
    send_byte(8'h55, 1);
    send_byte(8'h00, 0);
    core_result = 32'sd1000;
    core_result_valid = 1'b1;
    tick();
    core_result_valid = 1'b0;
    tick();
    chk("idle_no_drop", 32'(n_drop - snap), 32'd0);
    chk("idle_stray_busy", 32'(busy), 32'd0);
    chk("idle_stray_state", 32'(dbg_state), 32'(ST_IDLE));

    // Good frame; the last pixel lands on the timeout expiry cycle; bytes during WAIT are dropped
    send_header();
    chk("good_load_state", 32'(dbg_state), 32'(ST_LOAD));
    chk("good_busy", 32'(busy), 32'd1);
    send_pixels(NPIX, NPIX - 2);
    tick();
    tick();
    chk("good_no_tmo", 32'(n_tmo), 32'd0);
    chk("good_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    snap = n_drop;
    send_byte(8'h33, 1);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 2);
    tick();
    chk("wait_drops", 32'(n_drop - snap), 32'd3);
    s = '{32'sd5, -32'sd3, 32'sd9, 32'sd9, 32'sd2, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd1};
    finish_frame("good", s, 1'b1);
    chk("good_class_fixed", 32'(class_idx), 32'd2);
    chk("good_score_fixed", max_score, 32'sd9);
    check_pixels("good");

    // False sync: only the bytes after the real AA 55 are forwarded
    send_byte(8'hAA, 0);
    send_byte(8'h12, 1);
    send_byte(8'hAA, 0);
    send_byte(8'hAA, 2);
    send_byte(8'h55, 0);
    send_pixels(NPIX, 100);
    random_scores(s);
    finish_frame("fsync", s, 1'b1);
    check_pixels("fsync");

    // Header stall in SYNC falls back to IDLE with no error
    snap_tmo = n_tmo;
    send_byte(8'hAA, 0);
    repeat (T_TMO + 5) tick();
    chk("sync_tmo_idle", 32'(busy), 32'd0);
    chk("sync_tmo_silent", 32'(n_tmo - snap_tmo), 32'd0);

    // Timeout frame: 300 pixels then silence, zero padding, no done
    base = got_q.size();
    send_header();
    send_pixels(300, -1);
    for (int i = 0; i < NPIX - 300; i++) exp_q.push_back(8'h00);
    b = T_TMO + 20;
    while (n_tmo == snap_tmo && b > 0) begin
      tick();
      b--;
    end
    chk("tmo_seen", 32'(n_tmo - snap_tmo), 32'd1);
    chk("tmo_cycle", 32'(tmo_cyc), 32'(last_byte_cyc + T_TMO + 1));
    snap = n_drop;
    send_byte(8'hC3, 3);
    send_byte(8'h3C, 0);
    wait_pixels(NPIX, (NPIX - 300) * GAP + 200);
    chk("pad_drops", 32'(n_drop - snap), 32'd2);
    viol = 0;
    if (got_q.size() >= base + NPIX) begin
      chk("pad_first", 32'(got_t[base + 300]), 32'(tmo_cyc + GAP));
      for (int j = base + 301; j < base + NPIX; j++)
        if (got_t[j] - got_t[j - 1] != GAP) viol++;
    end
    chk("pad_spacing", 32'(viol), 32'd0);
    random_scores(s);
    finish_frame("tmo", s, 1'b0);
    check_pixels("tmo");

    // All-negative scores
    send_header();
    send_pixels(NPIX, -1);
    for (int i = 0; i < NCLS; i++) s[i] = -32'sd100;
    s[7] = -32'sd1;
    finish_frame("neg", s, 1'b1);
    chk("neg_class_fixed", 32'(class_idx), 32'd7);
    chk("neg_score_fixed", max_score, 32'hFFFF_FFFF);
    check_pixels("neg");

    // Reset after 400 pixels aborts the frame immediately
    send_header();
    send_pixels(400, -1);
    tick();
    tick();
    sys_rst_n = 1'b0;
    tick();
    m_frame_cnt = 0;
    m_class = '0;
    m_score = '0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_valid", 32'(core_valid_in), 32'd0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_class", 32'(class_idx), 32'd0);
    chk("mid_rst_score", max_score, 32'd0);
    check_pixels("mid_rst");
    sys_rst_n = 1'b1;
    tick();

    // Random good frames after reset, with ties likely among small scores
    for (int f = 0; f < 3; f++) begin
      send_header();
      send_pixels(NPIX, (f == 1) ? 377 : -1);
      random_scores(s);
      finish_frame($sformatf("rnd%0d", f), s, 1'b1);
      check_pixels($sformatf("rnd%0d", f));
    end
    chk("final_no_extra_tmo", 32'(n_tmo), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
